// File: rtl/aes_round_sequencer.sv
// Iterative AES control: accepts a {key, block} job, waits KEY_LAT cycles, then steps rounds 0..Nr.
// The result is valid KEY_LAT+Nr+2 cycles after the handshake; round_stall holds the round and out_ready holds DONE.
module aes_round_sequencer #(
  parameter int Nk      = 4,
  parameter int Nr      = 10,
  parameter int Nb      = 4,
  parameter int KEY_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [Nk*32-1:0]             key_in,
  input  logic [Nb*32-1:0]             data_in,
  output logic [Nk*32-1:0]             key_q,
  output logic [Nb*32-1:0]             data_q,
  input  logic [(Nr+1)*Nk*32-1:0]      keys_all,
  output logic [Nk*32-1:0]             round_key,
  output logic [$clog2(Nr+1)-1:0]      round_idx,
  output logic                         round_en,
  output logic                         round_first,
  output logic                         round_last,
  input  logic                         round_stall,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
);

  localparam int KW = Nk * 32;
  localparam int IW = $clog2(Nr + 1);
  localparam int CW = (KEY_LAT < 2) ? 1 : $clog2(KEY_LAT + 1);

  typedef enum logic [1:0] {IDLE, KWAIT, ROUND, DONE} state_e;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [CW-1:0] cnt_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      key_q       <= '0;
      data_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            key_q      <= key_in;
            data_q     <= data_in;
            cnt_q      <= CW'(KEY_LAT);
            state_q    <= KWAIT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        KWAIT: begin
          // key_q is already stable; this only lets the expansion registers settle
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= ROUND;
            idx_q   <= '0;
          end
        end
        ROUND: begin
          if (!round_stall) begin
            if (idx_q == IW'(Nr)) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          // in_ready only rises once IDLE is reached, so no same-cycle bypass
          if (out_ready) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign round_idx   = idx_q;
  assign round_key   = keys_all[int'(idx_q)*KW +: KW];
  assign round_en    = (state_q == ROUND) && !round_stall;
  assign round_first = round_en && (idx_q == '0);
  assign round_last  = round_en && (idx_q == IW'(Nr));

endmodule
